// File: rtl/program_loader.sv
// program_loader: packs a length-prefixed little-endian byte stream into words
// and writes them to instruction memory from address 0, holding the core in reset meanwhile.
module program_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [ADDR_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] WD,
    output logic                  WE,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int IW = BPW > 1 ? $clog2(BPW) : 1;
    localparam logic [63:0] DEPTH = 64'd1 << ADDR_WIDTH;
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, FINISH} state_t;
    state_t state, state_nxt;
    logic [15:0] len;
    logic [15:0] n_full;
    logic [16:0] cnt;
    logic [16:0] cnt_inc;
    logic [IW-1:0] idx;
    logic [DATA_WIDTH-1:0] wbuf;
    logic [DATA_WIDTH-1:0] word;
    logic last_byte;
    always_comb begin
        n_full = {rx_data, len[7:0]};
        last_byte = rx_valid && (int'(idx) == BPW - 1);
        cnt_inc = cnt + 17'd1;
        word = wbuf;
        word[8*int'(idx) +: 8] = rx_data;
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? LEN_LO : IDLE;
            LEN_LO:  state_nxt = rx_valid ? LEN_HI : LEN_LO;
            LEN_HI:  state_nxt = !rx_valid ? LEN_HI : (n_full == 16'd0 ? FINISH : DATA);
            DATA:    state_nxt = (last_byte && cnt_inc == {1'b0, len}) ? FINISH : DATA;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nxt;
    // Words past the memory depth are still consumed so the stream stays framed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A <= '0;
            WD <= '0;
            WE <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            overflow <= 1'b0;
            len <= '0;
            cnt <= '0;
            idx <= '0;
            wbuf <= '0;
        end else begin
            WE <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy <= 1'b1;
                    done <= 1'b0;
                    overflow <= 1'b0;
                    cnt <= '0;
                    idx <= '0;
                end
                LEN_LO: if (rx_valid) len[7:0] <= rx_data;
                LEN_HI: if (rx_valid) begin
                    len[15:8] <= rx_data;
                    overflow <= 64'(n_full) > DEPTH;
                end
                DATA: if (rx_valid) begin
                    wbuf <= word;
                    idx <= last_byte ? '0 : idx + IW'(1);
                    if (last_byte) begin
                        cnt <= cnt_inc;
                        if (64'(cnt) < DEPTH) begin
                            WE <= 1'b1;
                            A <= ADDR_WIDTH'(cnt);
                            WD <= word;
                        end
                    end
                end
                FINISH: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed and randomized frames checked against a word-level
// model of the expected memory writes and status flags.
module tb_program_loader;
    localparam int DW = 32;
    localparam int AW = 2;
    localparam int DEPTH = 1 << AW;
    logic clk = 1'b0;
    logic rst, start, rx_valid, WE, busy, done, overflow;
    logic [7:0] rx_data;
    logic [AW-1:0] A;
    logic [DW-1:0] WD;
    int total = 0;
    int bad = 0;
    int we_count = 0;
    logic [31:0] words [8];

    program_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .A(A), .WD(WD), .WE(WE), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (WE === 1'b1) we_count++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit s);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_data = b;
        rx_valid = 1'b1;
        start = s;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        start = 1'b0;
    endtask

    // Model: word k lands at address k only while k < DEPTH; flags follow N.
    task automatic do_load(input int n, input int maxgap, input bit sb, input bit poke);
        int we0;
        logic [15:0] nl;
        logic [7:0] bt;
        nl = 16'(n);
        rx_data = 8'hAA;
        rx_valid = sb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rx_valid = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        check("done_cleared", 32'(done), 0);
        we0 = we_count;
        send_byte(nl[7:0], $urandom_range(maxgap, 0), 1'b0);
        send_byte(nl[15:8], $urandom_range(maxgap, 0), 1'b0);
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < 4; b++) begin
                bt = words[w][8*b +: 8];
                send_byte(bt, $urandom_range(maxgap, 0), poke && w == 0 && b == 1);
            end
            if (w < DEPTH) begin
                check("we_pulse", 32'(WE), 1);
                check("we_addr", 32'(A), 32'(w));
                check("we_data", WD, words[w]);
            end else begin
                check("we_suppressed", 32'(WE), 0);
            end
        end
        check("busy_in_finish", 32'(busy), 1);
        check("done_in_finish", 32'(done), 0);
        @(posedge clk);
        #1;
        check("done_final", 32'(done), 1);
        check("busy_final", 32'(busy), 0);
        check("overflow_final", 32'(overflow), 32'(n > DEPTH));
        check("we_total", 32'(we_count - we0), 32'(n < DEPTH ? n : DEPTH));
    endtask

    initial begin
        int we0;
        rst = 1'b1;
        start = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_A", 32'(A), 0);
        check("rst_WD", WD, 0);
        check("rst_WE", 32'(WE), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_overflow", 32'(overflow), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Directed program from the reference frame
        words[0] = 32'h00000013;
        words[1] = 32'h00100093;
        do_load(2, 0, 1'b0, 1'b0);
        // Bytes in IDLE are ignored
        we0 = we_count;
        send_byte(8'h05, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        check("idle_busy", 32'(busy), 0);
        check("idle_done_kept", 32'(done), 1);
        check("idle_no_we", 32'(we_count - we0), 0);
        // Empty program
        do_load(0, 0, 1'b0, 1'b0);
        // Overflow: five words into a four-word memory, gapless
        for (int i = 0; i < 5; i++) words[i] = $urandom;
        do_load(5, 0, 1'b0, 1'b0);
        // start with a byte in IDLE drops the byte; start mid-load is ignored
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        do_load(3, 0, 1'b1, 1'b1);
        // Reset after six of eight data bytes
        words[0] = 32'hDEADBEEF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        for (int b = 0; b < 4; b++) send_byte(words[0][8*b +: 8], 0, 1'b0);
        check("pre_rst_we", 32'(WE), 1);
        check("pre_rst_wd", WD, 32'hDEADBEEF);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_A", 32'(A), 0);
        check("mid_rst_WD", WD, 0);
        check("mid_rst_WE", 32'(WE), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) words[i] = $urandom;
        do_load(2, 0, 1'b0, 1'b0);
        // Randomized lengths and inter-byte gaps
        for (int it = 0; it < 14; it++) begin
            int n;
            n = $urandom_range(6, 0);
            for (int i = 0; i < n; i++) words[i] = $urandom;
            do_load(n, (it % 2 == 0) ? 7 : 0, 1'b0, 1'b0);
            repeat ($urandom_range(3, 0)) @(posedge clk);
            #1;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
